hazard_unit: RTL and testbench

//   Stall/flush controller for the 5-stage ARM pipeline (F,D,E,M,W); counterpart of the E-stage forwarding unit.

---
 rtl/hazard_unit.sv | 122 ++++++++++++
 tb/tb_hazard_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, pending R15
// write and data-memory wait states, with a wait-timeout error flag and stall-cycle counter.
module hazard_unit #(
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3E,
    input  logic              regWriteE,
    input  logic              memtoRegE,
    input  logic              PCWrPendingF,
    input  logic              BranchTakenE,
    input  logic              memReqM,
    input  logic              memReadyM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushW,
    output logic              memErr,
    output logic [CNT_W-1:0]  stallCycles
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [WCW-1:0] wait_cnt;
    logic           abort_wait;
    logic           mem_stall;
    logic           ld_stall;

    assign abort_wait = (state == MEMWAIT) && !memReadyM && (wait_cnt == WCW'(TIMEOUT - 1));
    assign ld_stall   = memtoRegE && regWriteE && ((RA1D == WA3E) || (RA2D == WA3E));

    // A request that cannot complete now freezes F..M; once memErr is set, requests never stall.
    always_comb begin
        mem_stall  = 1'b0;
        state_next = state;
        case (state)
            RUN: begin
                if (memReqM && !memReadyM && !memErr) begin
                    mem_stall  = 1'b1;
                    state_next = MEMWAIT;
                end
            end
            MEMWAIT: begin
                if (memReadyM || abort_wait) begin
                    state_next = RUN;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            memErr   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == MEMWAIT && state_next == MEMWAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (abort_wait) begin
                memErr <= 1'b1;
            end
        end
    end

    // A taken branch squashes D, so it cancels the load-use hold of F/D and the PC.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (!reset_n) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushW = 1'b1;
        end else if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = (ld_stall || PCWrPendingF) && !BranchTakenE;
            stallD = ld_stall && !BranchTakenE;
            flushE = ld_stall || BranchTakenE;
            flushD = BranchTakenE || (PCWrPendingF && !ld_stall);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCycles <= '0;
        end else if (stallF && (stallCycles != {CNT_W{1'b1}})) begin
            stallCycles <= stallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; a narrow stall counter is used so saturation is reached.
module tb_hazard_unit;

    localparam int REG_AW  = 4;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic              clk;
    logic              reset_n;
    logic [REG_AW-1:0] RA1D, RA2D, WA3E;
    logic              regWriteE, memtoRegE, PCWrPendingF, BranchTakenE;
    logic              memReqM, memReadyM;
    logic              stallF, stallD, stallE, stallM;
    logic              flushD, flushE, flushW;
    logic              memErr;
    logic [CNT_W-1:0]  stallCycles;
    logic [6:0]        ctrl;

    int assertCount = 0;
    int failCount   = 0;
    int expCnt      = 0;

    hazard_unit #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
        .regWriteE(regWriteE), .memtoRegE(memtoRegE),
        .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE),
        .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .memErr(memErr), .stallCycles(stallCycles)
    );

    // ctrl bit order: stallF stallD stallE stallM flushD flushE flushW
    assign ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                                 input logic rw, input logic m2r, input logic pcw, input logic bt,
                                 input logic req, input logic rdy);
        RA1D = ra1; RA2D = ra2; WA3E = wa3;
        regWriteE = rw; memtoRegE = m2r; PCWrPendingF = pcw; BranchTakenE = bt;
        memReqM = req; memReadyM = rdy;
    endtask

    task automatic runCycle(input string tag, input logic [6:0] expCtrl);
        #2;
        checkOutput({tag, " ctrl"}, {25'd0, ctrl}, {25'd0, expCtrl});
        @(posedge clk);
        #1;
        if (expCtrl[6] && expCnt < (1 << CNT_W) - 1) expCnt++;
        checkOutput({tag, " cnt"}, {{(32-CNT_W){1'b0}}, stallCycles}, expCnt);
    endtask

    task automatic doReset(input string tag);
        reset_n = 1'b0;
        expCnt  = 0;
        #2;
        checkOutput({tag, " ctrl"}, {25'd0, ctrl}, 32'h07);
        checkOutput({tag, " memErr"}, {31'd0, memErr}, 32'd0);
        checkOutput({tag, " cnt"}, {{(32-CNT_W){1'b0}}, stallCycles}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        doReset("reset");

        // T5 pending R15 write
        applyStimulus(1, 2, 5, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) runCycle("T5 pcw", 7'b1000100);
        applyStimulus(1, 2, 5, 0, 0, 1, 1, 0, 0);
        runCycle("pcw+branch", 7'b0000110);

        // T1 load-use on both source ports, plus non-hazard cases
        applyStimulus(3, 7, 3, 1, 1, 0, 0, 0, 0);
        runCycle("T1 ld ra1", 7'b1100010);
        applyStimulus(6, 3, 3, 1, 1, 0, 0, 0, 0);
        runCycle("ld ra2", 7'b1100010);
        applyStimulus(4, 5, 3, 1, 1, 0, 0, 0, 0);
        runCycle("ld nomatch", 7'b0000000);
        applyStimulus(3, 3, 3, 0, 1, 0, 0, 0, 0);
        runCycle("ld norw", 7'b0000000);

        // T2 branch overrides load-use; load-use overrides pcw flushD
        applyStimulus(3, 7, 3, 1, 1, 0, 1, 0, 0);
        runCycle("T2 ld+branch", 7'b0000110);
        applyStimulus(3, 7, 3, 1, 1, 1, 0, 0, 0);
        runCycle("ld+pcw", 7'b1100010);

        // T3 three wait states with a load-use hazard masked, then release
        applyStimulus(3, 7, 3, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) runCycle("T3 wait", 7'b1111001);
        applyStimulus(3, 7, 3, 1, 1, 0, 0, 1, 1);
        runCycle("T3 release", 7'b1100010);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycle("run ready", 7'b0000000);

        // T4 timeout: 15 stalled cycles, then abort and sticky memErr
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TIMEOUT; i++) runCycle("T4 wait", 7'b1111001);
        checkOutput("T4 memErr pre", {31'd0, memErr}, 32'd0);
        runCycle("T4 abort", 7'b0000000);
        checkOutput("T4 memErr", {31'd0, memErr}, 32'd1);
        runCycle("T4 post", 7'b0000000);
        runCycle("T4 post2", 7'b0000000);
        checkOutput("T4 memErr sticky", {31'd0, memErr}, 32'd1);

        // T6 reset clears memErr, then reset while in MEMWAIT
        doReset("T6 reset1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        runCycle("T6 wait", 7'b1111001);
        runCycle("T6 wait2", 7'b1111001);
        doReset("T6 reset2");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("T6 run", 7'b0000000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
